// File: rtl/crossing_pkg.sv
// Shared types and helpers for the crossing supervisor.
package crossing_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WARN   = 3'd1,
    ST_LOWER  = 3'd2,
    ST_CLOSED = 3'd3,
    ST_CLEAR  = 3'd4,
    ST_RAISE  = 3'd5,
    ST_FAULT  = 3'd6
  } state_t;

  typedef struct packed {
    logic barrier;
    logic red;
    logic yellow;
    logic alarm;
  } lamps_t;

  // Lamp/barrier/alarm pattern for each state.
  function automatic lamps_t decode_outputs(state_t s);
    lamps_t l;
    l = '0;
    case (s)
      ST_WARN:   begin l.yellow = 1'b1; l.alarm = 1'b1; end
      ST_LOWER,
      ST_CLOSED,
      ST_FAULT:  begin l.red = 1'b1; l.alarm = 1'b1; l.barrier = 1'b1; end
      ST_CLEAR:  begin l.red = 1'b1; l.barrier = 1'b1; end
      ST_RAISE:  l.yellow = 1'b1;
      default:   l = '0;
    endcase
    return l;
  endfunction

  // Warning time scaled by weather (x1/x2/x4/x8), saturated to the timer width.
  function automatic logic [31:0] warn_load(int unsigned base, logic [1:0] mode,
                                            int unsigned width);
    logic [63:0] shifted;
    logic [63:0] limit;
    shifted = 64'(base) << mode;
    limit   = (64'd1 << width) - 64'd1;
    if (shifted > limit) shifted = limit;
    return shifted[31:0];
  endfunction

endpackage

// File: rtl/crossing_supervisor_n_fsm.sv
// Single-crossing phase FSM with phase timer and registered output decode.
module crossing_fsm
  import crossing_pkg::*;
#(
  parameter int unsigned WARN_CYCLES  = 16,
  parameter int unsigned LOWER_CYCLES = 8,
  parameter int unsigned CLEAR_CYCLES = 12,
  parameter int unsigned RAISE_CYCLES = 8,
  parameter int unsigned TIMER_W      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       detected,
  input  logic       exited,
  input  logic       health,
  input  logic       emergency,
  input  logic [1:0] weather_mode,
  output logic [2:0] state,
  output logic [2:0] state_next,
  output logic       barrier_down,
  output logic       red_light,
  output logic       yellow_light,
  output logic       alarm_sound
);

  localparam logic [TIMER_W-1:0] LOWER_L = TIMER_W'(LOWER_CYCLES);
  localparam logic [TIMER_W-1:0] CLEAR_L = TIMER_W'(CLEAR_CYCLES);
  localparam logic [TIMER_W-1:0] RAISE_L = TIMER_W'(RAISE_CYCLES);

  state_t               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  lamps_t               lamps_q;
  logic                 fault;
  logic                 expired;

  assign fault   = emergency | ~health;
  // A timer reading 1 (or 0 for a zero-length phase) ends the phase.
  assign expired = (timer_q <= TIMER_W'(1));

  // Next-state and timer logic; fault takes priority over every phase.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    if (fault) begin
      state_d = ST_FAULT;
      timer_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: if (detected) begin
          state_d = ST_WARN;
          timer_d = TIMER_W'(warn_load(WARN_CYCLES, weather_mode, TIMER_W));
        end
        ST_WARN: if (expired) begin
          state_d = ST_LOWER;
          timer_d = LOWER_L;
        end else timer_d = timer_q - 1'b1;
        ST_LOWER: if (expired) begin
          state_d = ST_CLOSED;
          timer_d = '0;
        end else timer_d = timer_q - 1'b1;
        ST_CLOSED: if (exited && !detected) begin
          state_d = ST_CLEAR;
          timer_d = CLEAR_L;
        end
        ST_CLEAR: if (detected) begin
          state_d = ST_CLOSED;
          timer_d = '0;
        end else if (expired) begin
          state_d = ST_RAISE;
          timer_d = RAISE_L;
        end else timer_d = timer_q - 1'b1;
        ST_RAISE: if (detected) begin
          state_d = ST_LOWER;
          timer_d = LOWER_L;
        end else if (expired) begin
          state_d = ST_IDLE;
          timer_d = '0;
        end else timer_d = timer_q - 1'b1;
        ST_FAULT: if (detected) begin
          state_d = ST_CLOSED;
          timer_d = '0;
        end else begin
          state_d = ST_CLEAR;
          timer_d = CLEAR_L;
        end
        default: begin
          state_d = ST_IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  // State, timer and outputs decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      lamps_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      lamps_q <= decode_outputs(state_d);
    end
  end

  assign state        = state_q;
  assign state_next   = state_d;
  assign barrier_down = lamps_q.barrier;
  assign red_light    = lamps_q.red;
  assign yellow_light = lamps_q.yellow;
  assign alarm_sound  = lamps_q.alarm;

endmodule

// File: rtl/crossing_supervisor_n.sv
// N-crossing supervisor: per-crossing FSMs, state-change event stream, active count.
module crossing_supervisor_n
  import crossing_pkg::*;
#(
  parameter int unsigned NUM_CROSSINGS = 4,
  parameter int unsigned WARN_CYCLES   = 16,
  parameter int unsigned LOWER_CYCLES  = 8,
  parameter int unsigned CLEAR_CYCLES  = 12,
  parameter int unsigned RAISE_CYCLES  = 8,
  parameter int unsigned TIMER_W       = 16,
  parameter int unsigned FIFO_DEPTH    = 8,
  localparam int unsigned IDX_W = (NUM_CROSSINGS > 1) ? $clog2(NUM_CROSSINGS) : 1,
  localparam int unsigned CNT_W = $clog2(NUM_CROSSINGS) + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CROSSINGS-1:0]   train_detected,
  input  logic [NUM_CROSSINGS-1:0]   train_exited,
  input  logic [NUM_CROSSINGS-1:0]   sensor_health,
  input  logic                       emergency_global,
  input  logic [1:0]                 weather_mode,
  output logic [NUM_CROSSINGS-1:0]   barrier_down,
  output logic [NUM_CROSSINGS-1:0]   red_light,
  output logic [NUM_CROSSINGS-1:0]   yellow_light,
  output logic [NUM_CROSSINGS-1:0]   alarm_sound,
  output logic [3*NUM_CROSSINGS-1:0] crossing_states,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [IDX_W+2:0]           evt_data,
  output logic [CNT_W-1:0]           active_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  logic [2:0]               st      [NUM_CROSSINGS];
  logic [2:0]               st_next [NUM_CROSSINGS];
  logic [NUM_CROSSINGS-1:0] changed;
  logic [NUM_CROSSINGS-1:0] pending_q, pending_d;
  logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic                     grant_valid;
  logic [IDX_W-1:0]         grant_idx;
  logic                     push, pop, full;
  logic [IDX_W+2:0]         push_data;
  logic [IDX_W+2:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]           count_q;
  logic [CNT_W-1:0]         active_d;

  for (genvar g = 0; g < NUM_CROSSINGS; g++) begin : g_xing
    crossing_fsm #(
      .WARN_CYCLES (WARN_CYCLES),
      .LOWER_CYCLES(LOWER_CYCLES),
      .CLEAR_CYCLES(CLEAR_CYCLES),
      .RAISE_CYCLES(RAISE_CYCLES),
      .TIMER_W     (TIMER_W)
    ) u_fsm (
      .clk         (clk),
      .rst         (rst),
      .detected    (train_detected[g]),
      .exited      (train_exited[g]),
      .health      (sensor_health[g]),
      .emergency   (emergency_global),
      .weather_mode(weather_mode),
      .state       (st[g]),
      .state_next  (st_next[g]),
      .barrier_down(barrier_down[g]),
      .red_light   (red_light[g]),
      .yellow_light(yellow_light[g]),
      .alarm_sound (alarm_sound[g])
    );
    assign crossing_states[3*g +: 3] = st[g];
    assign changed[g] = (st_next[g] != st[g]);
  end

  assign full      = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign evt_valid = (count_q != '0);
  assign evt_data  = mem[rd_ptr_q];
  assign pop       = evt_valid & evt_ready;

  // Round-robin pick of the first pending crossing at or after the pointer.
  always_comb begin
    int unsigned idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int unsigned k = 0; k < NUM_CROSSINGS; k++) begin
      idx = 32'(rr_ptr_q) + k;
      if (idx >= NUM_CROSSINGS) idx = idx - NUM_CROSSINGS;
      if (!grant_valid && pending_q[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(idx);
      end
    end
  end

  // Push, pending update and pointer advance; a change landing on the
  // granted crossing in the push cycle keeps its pending bit set.
  always_comb begin
    push      = grant_valid & (~full | pop);
    push_data = {grant_idx, st[grant_idx]};
    pending_d = pending_q | changed;
    rr_ptr_d  = rr_ptr_q;
    if (push) begin
      pending_d[grant_idx] = changed[grant_idx];
      rr_ptr_d = (grant_idx == IDX_W'(NUM_CROSSINGS - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Count of crossings that will be non-idle after this edge.
  always_comb begin
    active_d = '0;
    for (int unsigned i = 0; i < NUM_CROSSINGS; i++)
      if (st_next[i] != 3'(ST_IDLE)) active_d = active_d + 1'b1;
  end

  // Arbiter, FIFO pointers and active count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q    <= '0;
      rr_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      active_count <= '0;
    end else begin
      pending_q    <= pending_d;
      rr_ptr_q     <= rr_ptr_d;
      active_count <= active_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Event storage; contents are only meaningful below the count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: tb/tb_crossing_supervisor_n.sv
// Scoreboard bench for crossing_supervisor_n with four crossings.
module tb_crossing_supervisor_n;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  train_detected, train_exited, sensor_health;
  logic        emergency_global;
  logic [1:0]  weather_mode;
  logic [3:0]  barrier_down, red_light, yellow_light, alarm_sound;
  logic [11:0] crossing_states;
  logic        evt_valid, evt_ready;
  logic [4:0]  evt_data;
  logic [2:0]  active_count;

  int          compared   = 0;
  int          mismatched = 0;
  int          cur_edge;
  logic        sb_en = 1'b0;
  logic [4:0]  exp_q [$];

  crossing_supervisor_n #(
    .NUM_CROSSINGS(4), .WARN_CYCLES(16), .LOWER_CYCLES(8), .CLEAR_CYCLES(12),
    .RAISE_CYCLES(8), .TIMER_W(16), .FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .rst(rst), .train_detected(train_detected), .train_exited(train_exited),
    .sensor_health(sensor_health), .emergency_global(emergency_global),
    .weather_mode(weather_mode), .barrier_down(barrier_down), .red_light(red_light),
    .yellow_light(yellow_light), .alarm_sound(alarm_sound),
    .crossing_states(crossing_states), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_data(evt_data), .active_count(active_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Expected {barrier, red, yellow, alarm} per state.
  function automatic logic [3:0] exp_lamps(logic [2:0] s);
    case (s)
      3'd1:          return 4'b0011;
      3'd2, 3'd3, 3'd6: return 4'b1101;
      3'd4:          return 4'b1100;
      3'd5:          return 4'b0010;
      default:       return 4'b0000;
    endcase
  endfunction

  function automatic logic [2:0] get_state(int i);
    return crossing_states[3*i +: 3];
  endfunction

  function automatic logic [3:0] act_lamps(int i);
    return {barrier_down[i], red_light[i], yellow_light[i], alarm_sound[i]};
  endfunction

  function automatic logic [4:0] evt(int idx, int s);
    return 5'((idx << 3) | s);
  endfunction

  task automatic step();
    @(posedge clk); #1;
    cur_edge++;
  endtask

  task automatic goto_edge(int k);
    while (cur_edge < k) step();
  endtask

  // Event consumer: every accepted event is compared with the scoreboard head.
  initial forever begin
    @(negedge clk);
    if (sb_en && evt_valid === 1'b1 && evt_ready === 1'b1) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL evt_unexpected: got %h required none", evt_data);
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        if (evt_data !== e) begin
          mismatched++;
          $display("FAIL evt_data: got %h required %h", evt_data, e);
        end
      end
    end
  end

  task automatic apply_reset();
    rst = 1'b1;
    train_detected = '0; train_exited = '0; sensor_health = '1;
    emergency_global = 1'b0; weather_mode = 2'd0; evt_ready = 1'b0;
    sb_en = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cur_edge = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    train_detected = '0; train_exited = '0; sensor_health = '1;
    emergency_global = 1'b0; weather_mode = 2'd0; evt_ready = 1'b0;
    #3;
    compared++;
    if ({crossing_states, barrier_down, red_light, yellow_light, alarm_sound,
         evt_valid, active_count} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: got st=%h bar=%b red=%b yel=%b alm=%b v=%b act=%0d required all 0",
               crossing_states, barrier_down, red_light, yellow_light, alarm_sound,
               evt_valid, active_count);
    end
    apply_reset();
  endtask

  task automatic test_nominal();
    int e [11] = '{0, 15, 16, 23, 24, 39, 40, 51, 52, 59, 60};
    int s [11] = '{1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 0};
    apply_reset();
    evt_ready = 1'b1;
    sb_en = 1'b1;
    foreach (s[j]) if (j < 5) exp_q.push_back(evt(0, s[2*j+1 > 9 ? 9 : 2*j+1]));
    exp_q.delete();
    exp_q.push_back(evt(0, 1)); exp_q.push_back(evt(0, 2)); exp_q.push_back(evt(0, 3));
    exp_q.push_back(evt(0, 4)); exp_q.push_back(evt(0, 5)); exp_q.push_back(evt(0, 0));
    train_detected[0] = 1'b1;
    for (int j = 0; j < 11; j++) begin
      goto_edge(e[j]);
      compared++;
      if (get_state(0) !== 3'(s[j])) begin
        mismatched++;
        $display("FAIL nominal_state@%0d: got %0d required %0d", e[j], get_state(0), s[j]);
      end
      compared++;
      if (act_lamps(0) !== exp_lamps(3'(s[j]))) begin
        mismatched++;
        $display("FAIL nominal_lamps@%0d: got %b required %b", e[j], act_lamps(0),
                 exp_lamps(3'(s[j])));
      end
      compared++;
      if (active_count !== ((s[j] != 0) ? 3'd1 : 3'd0)) begin
        mismatched++;
        $display("FAIL nominal_active@%0d: got %0d required %0d", e[j], active_count,
                 (s[j] != 0) ? 1 : 0);
      end
      if (e[j] == 24) train_detected[0] = 1'b0;
      if (e[j] == 39) train_exited[0] = 1'b1;
      if (e[j] == 40) train_exited[0] = 1'b0;
    end
    goto_edge(66);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL nominal_evt_left: got %0d outstanding required 0", exp_q.size());
    end
    sb_en = 1'b0;
  endtask

  task automatic test_weather_storm();
    apply_reset();
    weather_mode = 2'd3;
    train_detected[1] = 1'b1;
    goto_edge(0);
    compared++;
    if (get_state(1) !== 3'd1) begin
      mismatched++;
      $display("FAIL storm_enter: got %0d required 1", get_state(1));
    end
    goto_edge(10);
    weather_mode = 2'd0;
    goto_edge(127);
    compared++;
    if (get_state(1) !== 3'd1 || act_lamps(1) !== 4'b0011) begin
      mismatched++;
      $display("FAIL storm_warn_end: got st=%0d lamps=%b required st=1 lamps=0011",
               get_state(1), act_lamps(1));
    end
    goto_edge(128);
    compared++;
    if (get_state(1) !== 3'd2) begin
      mismatched++;
      $display("FAIL storm_lower: got %0d required 2", get_state(1));
    end
    compared++;
    if (get_state(0) !== 3'd0) begin
      mismatched++;
      $display("FAIL storm_other_idle: got %0d required 0", get_state(0));
    end
  endtask

  task automatic test_reentry();
    int ce [8] = '{24, 30, 33, 34, 40, 53, 54, 61};
    int cs [8] = '{3, 4, 4, 3, 4, 5, 2, 2};
    apply_reset();
    train_detected[0] = 1'b1;
    for (int j = 0; j < 8; j++) begin
      goto_edge(ce[j]);
      compared++;
      if (get_state(0) !== 3'(cs[j]) || act_lamps(0) !== exp_lamps(3'(cs[j]))) begin
        mismatched++;
        $display("FAIL reentry@%0d: got st=%0d lamps=%b required st=%0d lamps=%b", ce[j],
                 get_state(0), act_lamps(0), cs[j], exp_lamps(3'(cs[j])));
      end
      if (ce[j] == 24) begin
        train_detected[0] = 1'b0;
        goto_edge(29);
        train_exited[0] = 1'b1;
      end
      if (ce[j] == 30) train_exited[0] = 1'b0;
      if (ce[j] == 33) train_detected[0] = 1'b1;
      if (ce[j] == 34) begin
        train_detected[0] = 1'b0;
        goto_edge(39);
        train_exited[0] = 1'b1;
      end
      if (ce[j] == 40) train_exited[0] = 1'b0;
      if (ce[j] == 53) train_detected[0] = 1'b1;
    end
    goto_edge(62);
    compared++;
    if (get_state(0) !== 3'd3 || barrier_down[0] !== 1'b1) begin
      mismatched++;
      $display("FAIL reentry_closed: got st=%0d bar=%b required st=3 bar=1",
               get_state(0), barrier_down[0]);
    end
  endtask

  task automatic test_emergency();
    apply_reset();
    train_detected[1] = 1'b1;
    goto_edge(19);
    train_detected[0] = 1'b1;
    goto_edge(30);
    compared++;
    if (crossing_states !== 12'h0_0_3_1 >> 0 && crossing_states !== {3'd0, 3'd0, 3'd3, 3'd1}) begin
      mismatched++;
      $display("FAIL emerg_setup: got %h required %h", crossing_states, {3'd0, 3'd0, 3'd3, 3'd1});
    end
    train_detected = '0;
    emergency_global = 1'b1;
    goto_edge(31);
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (get_state(i) !== 3'd6 || act_lamps(i) !== 4'b1101) begin
        mismatched++;
        $display("FAIL emerg_fault[%0d]: got st=%0d lamps=%b required st=6 lamps=1101",
                 i, get_state(i), act_lamps(i));
      end
    end
    compared++;
    if (active_count !== 3'd4) begin
      mismatched++;
      $display("FAIL emerg_active: got %0d required 4", active_count);
    end
    goto_edge(34);
    emergency_global = 1'b0;
    goto_edge(35);
    compared++;
    if (crossing_states !== {3'd4, 3'd4, 3'd4, 3'd4}) begin
      mismatched++;
      $display("FAIL emerg_clear_start: got %h required %h", crossing_states, {4{3'd4}});
    end
    goto_edge(46);
    compared++;
    if (crossing_states !== {3'd4, 3'd4, 3'd4, 3'd4}) begin
      mismatched++;
      $display("FAIL emerg_clear_end: got %h required %h", crossing_states, {4{3'd4}});
    end
    goto_edge(47);
    compared++;
    if (crossing_states !== {3'd5, 3'd5, 3'd5, 3'd5}) begin
      mismatched++;
      $display("FAIL emerg_raise: got %h required %h", crossing_states, {4{3'd5}});
    end
    sensor_health[3] = 1'b0;
    train_detected[3] = 1'b1;
    goto_edge(48);
    compared++;
    if (crossing_states !== {3'd6, 3'd5, 3'd5, 3'd5}) begin
      mismatched++;
      $display("FAIL health_fault: got %h required %h", crossing_states, {3'd6, 3'd5, 3'd5, 3'd5});
    end
    sensor_health[3] = 1'b1;
    goto_edge(49);
    compared++;
    if (get_state(3) !== 3'd3) begin
      mismatched++;
      $display("FAIL fault_exit_detected: got %0d required 3", get_state(3));
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    sb_en = 1'b1;
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < 4; i++)
        exp_q.push_back(evt(i, (r == 0) ? 1 : (r == 1) ? 2 : 3));
    train_detected = '1;
    goto_edge(21);
    emergency_global = 1'b1;
    goto_edge(22);
    compared++;
    if (crossing_states !== {4{3'd6}}) begin
      mismatched++;
      $display("FAIL bp_fault: got %h required %h", crossing_states, {4{3'd6}});
    end
    goto_edge(24);
    emergency_global = 1'b0;
    goto_edge(25);
    compared++;
    if (crossing_states !== {4{3'd3}}) begin
      mismatched++;
      $display("FAIL bp_closed: got %h required %h", crossing_states, {4{3'd3}});
    end
    for (int k = 26; k <= 30; k++) begin
      goto_edge(k);
      compared++;
      if (evt_valid !== 1'b1 || evt_data !== evt(0, 1)) begin
        mismatched++;
        $display("FAIL bp_stall@%0d: got v=%b d=%h required v=1 d=%h", k, evt_valid,
                 evt_data, evt(0, 1));
      end
    end
    evt_ready = 1'b1;
    goto_edge(50);
    compared++;
    if (exp_q.size() != 0 || evt_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL bp_drain: got %0d outstanding v=%b required 0 outstanding v=0",
               exp_q.size(), evt_valid);
    end
    sb_en = 1'b0;
  endtask

  task automatic test_async_reset();
    apply_reset();
    train_detected = '1;
    goto_edge(30);
    compared++;
    if (crossing_states !== {4{3'd3}} || evt_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL ar_setup: got st=%h v=%b required st=%h v=1", crossing_states,
               evt_valid, {4{3'd3}});
    end
    #2 rst = 1'b1;
    train_detected = '0;
    #1;
    compared++;
    if ({crossing_states, barrier_down, red_light, yellow_light, alarm_sound,
         evt_valid, active_count} !== '0) begin
      mismatched++;
      $display("FAIL ar_immediate: got st=%h bar=%b red=%b alm=%b v=%b act=%0d required all 0",
               crossing_states, barrier_down, red_light, alarm_sound, evt_valid, active_count);
    end
    @(posedge clk); #1 rst = 1'b0;
    cur_edge = -1;
    train_detected[2] = 1'b1;
    goto_edge(0);
    compared++;
    if (crossing_states !== {3'd0, 3'd1, 3'd0, 3'd0} || evt_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL ar_fresh_warn: got st=%h v=%b required st=%h v=0", crossing_states,
               evt_valid, {3'd0, 3'd1, 3'd0, 3'd0});
    end
    train_detected[2] = 1'b0;
    goto_edge(1);
    compared++;
    if (get_state(2) !== 3'd1 || evt_valid !== 1'b1 || evt_data !== evt(2, 1)) begin
      mismatched++;
      $display("FAIL ar_first_event: got st=%0d v=%b d=%h required st=1 v=1 d=%h",
               get_state(2), evt_valid, evt_data, evt(2, 1));
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_weather_storm();
    test_reentry();
    test_emergency();
    test_backpressure();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
